// File: rtl/hilo_unit.sv
// hilo_unit: architectural HI/LO register pair for a MIPS-style core.
// Executes MULT/MULTU locally in one extra cycle, hands DIV off to an
// external stream_divider, and writes MTHI/MTLO immediately.
// busy stalls MFHI/MFLO in the pipeline while a multiply or divide is in flight.

module hilo_unit #(
  parameter int unsigned width = 32
) (
  input  logic             clk,
  input  logic             reset,         // asynchronous, active low

  // Request side
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [width-1:0] rs_val,
  input  logic [width-1:0] rt_val,
  input  logic             flush,
  output logic             op_ready,
  output logic             busy,

  // Architectural state
  output logic [width-1:0] hi,
  output logic [width-1:0] lo,

  // stream_divider handshake
  output logic             div_start,
  output logic [width-1:0] div_dividend,
  output logic [width-1:0] div_divisor,
  input  logic             div_done,
  input  logic [width-1:0] div_quotient,
  input  logic [width-1:0] div_reminder
);

  localparam logic [2:0] OpNone  = 3'b000;
  localparam logic [2:0] OpMult  = 3'b001;
  localparam logic [2:0] OpMultu = 3'b010;
  localparam logic [2:0] OpDiv   = 3'b011;
  localparam logic [2:0] OpMthi  = 3'b100;
  localparam logic [2:0] OpMtlo  = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDivw
  } state_e;

  state_e           state_q;
  logic [width-1:0] hi_q;
  logic [width-1:0] lo_q;
  logic [width-1:0] mul_a_q;
  logic [width-1:0] mul_b_q;
  logic             mul_signed_q;
  logic             div_start_q;
  logic [width-1:0] div_dividend_q;
  logic [width-1:0] div_divisor_q;

  logic [2*width-1:0] mul_a_ext;
  logic [2*width-1:0] mul_b_ext;
  logic [2*width-1:0] product;

  // Product of the registered operands. Extending both operands to 2*width
  // (sign- or zero-) and keeping the low 2*width bits gives the exact signed
  // or unsigned product with a single multiplier.
  always_comb begin
    mul_a_ext = {{width{mul_signed_q & mul_a_q[width-1]}}, mul_a_q};
    mul_b_ext = {{width{mul_signed_q & mul_b_q[width-1]}}, mul_b_q};
    product   = mul_a_ext * mul_b_ext;
  end

  // Control FSM plus all architectural and divider-facing registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      hi_q           <= '0;
      lo_q           <= '0;
      mul_a_q        <= '0;
      mul_b_q        <= '0;
      mul_signed_q   <= 1'b0;
      div_start_q    <= 1'b0;
      div_dividend_q <= '0;
      div_divisor_q  <= '0;
    end else if (flush) begin
      // Abort: drop any in-flight result, keep HI/LO, accept nothing this edge.
      state_q     <= StIdle;
      div_start_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (op_valid) begin
            case (op)
              OpMult, OpMultu: begin
                mul_a_q      <= rs_val;
                mul_b_q      <= rt_val;
                mul_signed_q <= (op == OpMult);
                state_q      <= StMul;
              end
              OpDiv: begin
                if (rt_val == '0) begin
                  // Divide by zero resolves locally; the divider is never started.
                  hi_q <= rs_val;
                  lo_q <= '1;
                end else begin
                  // Operands are held until DIVW is left: the divider reads the
                  // live dividend when fixing the remainder sign.
                  div_dividend_q <= rs_val;
                  div_divisor_q  <= rt_val;
                  div_start_q    <= 1'b1;
                  state_q        <= StDivw;
                end
              end
              OpMthi: hi_q <= rs_val;
              OpMtlo: lo_q <= rs_val;
              OpNone: ;
              default: ;
            endcase
          end
        end
        StMul: begin
          {hi_q, lo_q} <= product;
          state_q      <= StIdle;
        end
        StDivw: begin
          if (div_done) begin
            lo_q        <= div_quotient;
            hi_q        <= div_reminder;
            div_start_q <= 1'b0;
            // Returning through IDLE guarantees a start-low cycle before the
            // next divide, so the divider counter rewinds.
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q     <= StIdle;
          div_start_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = (state_q != StIdle);
  assign op_ready     = ~busy;
  assign hi           = hi_q;
  assign lo           = lo_q;
  assign div_start    = div_start_q;
  assign div_dividend = div_dividend_q;
  assign div_divisor  = div_divisor_q;

endmodule

// File: doc/hilo_unit.md
HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 Parameter: width, 32, data width of operands, HI and LO.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 op_valid  input  1  operation request qualifier.
REQ-005 op  input  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 MTHI, 101 MTLO; 110/111 ignored.
REQ-006 rs_val  input  width  first operand (dividend, multiplicand, MTHI/MTLO source).
REQ-007 rt_val  input  width  second operand (divisor, multiplier).
REQ-008 flush  input  1  abort any in-flight operation.
REQ-009 op_ready  output  1  high when a request is accepted this cycle; equals !busy.
REQ-010 busy  output  1  high while a MULT/DIV is in flight; pipeline stalls MFHI/MFLO on it.
REQ-011 hi, lo  output  width each  architectural HI/LO registers.
REQ-012 div_start  output  1  drives stream_divider start.
REQ-013 div_dividend, div_divisor  output  width each  operands to stream_divider.
REQ-014 div_done  input  1  stream_divider done pulse.
REQ-015 div_quotient, div_reminder  input  width each  stream_divider results.

Function
REQ-016 States SHALL be IDLE, MUL, DIVW; busy = (state != IDLE).
REQ-017 A request SHALL be accepted only on an edge with op_valid=1, state=IDLE and flush=0; otherwise op, rs_val and rt_val are ignored.
REQ-018 MTHI/MTLO SHALL write rs_val to hi/lo on the accepting edge; state stays IDLE.
REQ-019 MULT/MULTU SHALL register operands, go to MUL, and on the next edge write the 2*width product {hi,lo} (signed for MULT, unsigned for MULTU), then return to IDLE; latency 2 edges, busy high 1 cycle.
REQ-020 DIV with rt_val=0 SHALL not enter DIVW: on the accepting edge hi <= rs_val and lo <= all ones; div_start stays 0.
REQ-021 DIV with rt_val!=0 SHALL latch rs_val/rt_val into div_dividend/div_divisor and enter DIVW.
REQ-022 div_start SHALL be 1 exactly while state=DIVW (registered, no combinational path from op).
REQ-023 div_dividend and div_divisor SHALL stay constant from acceptance until the edge that leaves DIVW, since the divider's remainder sign uses the live dividend.
REQ-024 In DIVW, on an edge with div_done=1: lo <= div_quotient, hi <= div_reminder, state <= IDLE.
REQ-025 With stream_divider attached, hi/lo SHALL update on the 35th edge after the accepting edge; busy high 35 cycles.
REQ-026 Back-to-back DIVs SHALL have at least one cycle with div_start=0 between them, so the divider counter returns to 0.
REQ-027 flush=1 SHALL force state to IDLE on that edge, drop div_start, discard any in-flight result, leave hi/lo unchanged and accept nothing that edge.
REQ-028 flush on the same edge as div_done=1 SHALL win: result discarded.
REQ-029 op_valid with op 000/110/111 SHALL be a no-op and is accepted.
REQ-030 hi/lo SHALL change only per REQ-018..REQ-024.

Reset
REQ-031 reset=0 SHALL immediately, without a clock, set state=IDLE, hi=0, lo=0, div_start=0, div_dividend=0, div_divisor=0, busy=0; op_ready=1 after release.
REQ-032 Reset asserted mid-divide SHALL abort it with the same values; the divider is reset by its own reset.

Verification
REQ-033 Reset release, idle 5 cycles -> hi=0, lo=0, busy=0, div_start=0 throughout.
REQ-034 MULT rs=FFFFFFFD, rt=00000005 -> hi=FFFFFFFF, lo=FFFFFFF1 two edges after accept; MULTU rs=FFFFFFFF, rt=2 -> hi=00000001, lo=FFFFFFFE.
REQ-035 DIV rs=FFFFFFF9 (-7), rt=2 -> busy 35 cycles, div_start 1 throughout, then lo=FFFFFFFD, hi=FFFFFFFF; operands stable on divider ports throughout.
REQ-036 DIV rs=12345678, rt=0 -> hi=12345678, lo=FFFFFFFF on accepting edge, busy never 1, div_start never 1.
REQ-037 DIV 100/7 with flush pulsed at cycle 10 and an MTLO 0000AAAA presented while busy -> MTLO ignored until idle, hi/lo unchanged by divide, next DIV 100/7 gives lo=0000000E, hi=00000002.
REQ-038 Back-to-back DIV 9/3 then DIV -9/3 with op_valid held -> one div_start-low cycle between; results lo=3, hi=0 then lo=FFFFFFFD, hi=0.
